// File: rtl/audio_level_meter.sv
// Microphone level meter: per-window peak or average magnitude, quantised to a
// bar-graph level, with an optional peak-hold that decays after a hold period.
module audio_level_meter #(
    parameter int SAMPLE_W     = 12,
    parameter int LEVELS       = 16,
    parameter int WINDOW       = 4096,
    parameter int HOLD_WINDOWS = 8
) (
    input  logic                         CLOCK,
    input  logic                         RESET,
    input  logic                         sample_valid,
    input  logic [SAMPLE_W-1:0]          sample,
    input  logic                         mode,
    input  logic                         hold_en,
    output logic [$clog2(LEVELS+1)-1:0]  level,
    output logic [LEVELS-1:0]            led,
    output logic [$clog2(LEVELS+1)-1:0]  hold_level,
    output logic                         level_valid
);

    localparam int MAG_W  = SAMPLE_W - 1;
    localparam int LOG2W  = $clog2(WINDOW);
    localparam int ACC_W  = MAG_W + LOG2W;
    localparam int LVL_W  = $clog2(LEVELS + 1);
    localparam int PROD_W = MAG_W + LVL_W;
    localparam int HC_W   = (HOLD_WINDOWS > 1) ? $clog2(HOLD_WINDOWS) : 1;

    localparam logic [SAMPLE_W-1:0] MID       = {1'b1, {MAG_W{1'b0}}};
    localparam logic [SAMPLE_W-1:0] MAG_MAX_W = {1'b0, {MAG_W{1'b1}}};
    localparam logic [MAG_W-1:0]    MAG_MAX   = {MAG_W{1'b1}};
    localparam logic [LOG2W-1:0]    CNT_LAST  = LOG2W'(WINDOW - 1);
    localparam logic [HC_W-1:0]     HC_LAST   = HC_W'(HOLD_WINDOWS - 1);
    localparam logic [PROD_W-1:0]   LVL_MULT  = PROD_W'(LEVELS + 1);

    typedef enum logic {ACCUM, CLOSE} state_t;

    state_t              state_q, state_d;
    logic [MAG_W-1:0]    mag_q, mag_d;
    logic                mag_valid_q, mag_valid_d;
    logic                mode_s1_q, mode_s1_d;
    logic [LOG2W-1:0]    cnt_q, cnt_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic                win_mode_q, win_mode_d;
    logic [LVL_W-1:0]    level_q, level_d;
    logic [LEVELS-1:0]   led_q, led_d;
    logic [LVL_W-1:0]    hold_q, hold_d;
    logic [HC_W-1:0]     hold_cnt_q, hold_cnt_d;
    logic                level_valid_q, level_valid_d;

    logic [SAMPLE_W-1:0] diff;
    logic [ACC_W-1:0]    mag_ext;
    logic                first;
    logic [MAG_W-1:0]    metric;
    logic [PROD_W-1:0]   prod;
    logic [LVL_W-1:0]    level_new;

    // Stage 1: distance from mid-scale; the single value 2^(SAMPLE_W-1) is clipped.
    always_comb begin
        diff        = (sample >= MID) ? (sample - MID) : (MID - sample);
        mag_d       = mag_q;
        mode_s1_d   = mode_s1_q;
        mag_valid_d = sample_valid;
        if (sample_valid) begin
            mag_d     = (diff > MAG_MAX_W) ? MAG_MAX : diff[MAG_W-1:0];
            mode_s1_d = mode;
        end
    end

    // Stage 2: window accumulation. CLOSE reads the finished window while a
    // magnitude arriving in the same cycle opens the next one.
    always_comb begin
        mag_ext    = ACC_W'(mag_q);
        state_d    = ACCUM;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        win_mode_d = win_mode_q;
        first      = (state_q == CLOSE) || (cnt_q == '0);
        if (state_q == CLOSE) begin
            acc_d = '0;
        end
        if (mag_valid_q) begin
            if (first) begin
                acc_d      = mag_ext;
                win_mode_d = mode_s1_q;
            end else if (win_mode_q) begin
                acc_d = acc_q + mag_ext;
            end else if (mag_ext > acc_q) begin
                acc_d = mag_ext;
            end
            if (cnt_q == CNT_LAST) begin
                cnt_d   = '0;
                state_d = CLOSE;
            end else begin
                cnt_d = cnt_q + LOG2W'(1);
            end
        end
    end

    // Stage 3: quantise and apply peak-hold once per closed window.
    always_comb begin
        metric        = win_mode_q ? MAG_W'(acc_q >> LOG2W) : acc_q[MAG_W-1:0];
        prod          = PROD_W'(metric) * LVL_MULT;
        level_new     = LVL_W'(prod >> MAG_W);
        level_d       = level_q;
        hold_d        = hold_q;
        hold_cnt_d    = hold_cnt_q;
        level_valid_d = 1'b0;
        if (state_q == CLOSE) begin
            level_d       = level_new;
            level_valid_d = 1'b1;
            if (!hold_en) begin
                hold_d     = level_new;
                hold_cnt_d = '0;
            end else if (level_new > hold_q) begin
                hold_d     = level_new;
                hold_cnt_d = '0;
            end else if (hold_cnt_q == HC_LAST) begin
                hold_d = (hold_q != '0) ? (hold_q - LVL_W'(1)) : '0;
            end else begin
                hold_cnt_d = hold_cnt_q + HC_W'(1);
            end
        end
    end

    for (genvar gi = 0; gi < LEVELS; gi++) begin : g_led
        assign led_d[gi] = (level_d > LVL_W'(gi));
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q       <= ACCUM;
            mag_q         <= '0;
            mag_valid_q   <= 1'b0;
            mode_s1_q     <= 1'b0;
            cnt_q         <= '0;
            acc_q         <= '0;
            win_mode_q    <= 1'b0;
            level_q       <= '0;
            led_q         <= '0;
            hold_q        <= '0;
            hold_cnt_q    <= '0;
            level_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            mag_q         <= mag_d;
            mag_valid_q   <= mag_valid_d;
            mode_s1_q     <= mode_s1_d;
            cnt_q         <= cnt_d;
            acc_q         <= acc_d;
            win_mode_q    <= win_mode_d;
            level_q       <= level_d;
            led_q         <= led_d;
            hold_q        <= hold_d;
            hold_cnt_q    <= hold_cnt_d;
            level_valid_q <= level_valid_d;
        end
    end

    assign level       = level_q;
    assign led         = led_q;
    assign hold_level  = hold_q;
    assign level_valid = level_valid_q;

endmodule

// File: tb/tb_audio_level_meter.sv
// Bench for audio_level_meter: windows are modelled as lists of magnitudes and
// every level_valid pulse is compared against the model's expected pulse list.
module tb_audio_level_meter;

    localparam int SW = 12;
    localparam int LV = 16;
    localparam int WN = 4;
    localparam int HW = 2;

    logic          CLOCK = 1'b0;
    logic          RESET;
    logic          sample_valid;
    logic [SW-1:0] sample;
    logic          mode;
    logic          hold_en;
    logic [4:0]    level;
    logic [LV-1:0] led;
    logic [4:0]    hold_level;
    logic          level_valid;

    audio_level_meter #(
        .SAMPLE_W(SW), .LEVELS(LV), .WINDOW(WN), .HOLD_WINDOWS(HW)
    ) dut (
        .CLOCK(CLOCK), .RESET(RESET), .sample_valid(sample_valid),
        .sample(sample), .mode(mode), .hold_en(hold_en), .level(level),
        .led(led), .hold_level(hold_level), .level_valid(level_valid)
    );

    always #5 CLOCK = ~CLOCK;

    int cyc = 0;
    always @(posedge CLOCK) cyc <= cyc + 1;

    typedef struct packed {int c; int lvl; int ld; int hld;} pulse_t;
    pulse_t seen[$];
    pulse_t expq[$];

    always @(negedge CLOCK)
        if (level_valid === 1'b1)
            seen.push_back('{cyc, int'(level), int'(led), int'(hold_level)});

    int checks = 0;
    int errors = 0;

    int win_mags[$];
    bit win_mode;
    int m_hold = 0;
    int m_hcnt = 0;

    function automatic int magnitude(input int s);
        int m = s - 2048;
        if (m < 0) m = -m;
        return (m > 2047) ? 2047 : m;
    endfunction

    // Model: a window is the list of its magnitudes; pulse seen 2 edges after the last strobe.
    task automatic accept(input int s, input bit md, input int k);
        int metric;
        int lvl;
        int sum;
        if (win_mags.size() == 0) win_mode = md;
        win_mags.push_back(magnitude(s));
        if (win_mags.size() == WN) begin
            sum = 0;
            metric = 0;
            foreach (win_mags[i]) begin
                sum += win_mags[i];
                if (win_mags[i] > metric) metric = win_mags[i];
            end
            if (win_mode) metric = sum / WN;
            lvl = metric * (LV + 1) / 2048;
            if (!hold_en) begin
                m_hold = lvl; m_hcnt = 0;
            end else if (lvl > m_hold) begin
                m_hold = lvl; m_hcnt = 0;
            end else if (m_hcnt == HW - 1) begin
                m_hold = (m_hold > 0) ? m_hold - 1 : 0;
            end else begin
                m_hcnt++;
            end
            expq.push_back('{k + 2, lvl, (1 << lvl) - 1, m_hold});
            win_mags.delete();
        end
    endtask

    task automatic put(input int s, input bit md);
        sample_valid = 1'b1;
        sample = s[SW-1:0];
        mode = md;
        @(negedge CLOCK);
        accept(s, md, cyc);
    endtask

    task automatic idle(input int n);
        sample_valid = 1'b0;
        repeat (n) @(negedge CLOCK);
    endtask

    task automatic do_reset();
        sample_valid = 1'b0;
        RESET = 1'b1;
        repeat (2) @(negedge CLOCK);
        RESET = 1'b0;
        win_mags.delete();
        m_hold = 0;
        m_hcnt = 0;
    endtask

    task automatic test_reset();
        RESET = 1'b1; sample_valid = 1'b0; sample = '0; mode = 1'b0; hold_en = 1'b0;
        repeat (3) @(negedge CLOCK);
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL reset_level: got %0d, expected 0", level); end
        checks++; if (led !== 16'h0) begin errors++; $display("FAIL reset_led: got %h, expected 0000", led); end
        checks++; if (hold_level !== 5'd0) begin errors++; $display("FAIL reset_hold: got %0d, expected 0", hold_level); end
        checks++; if (level_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, expected 0", level_valid); end
        RESET = 1'b0;
        @(negedge CLOCK);
        $display("reset: outputs level=%0d led=%h hold=%0d", level, led, hold_level);
    endtask

    task automatic test_peak();
        hold_en = 1'b0;
        put(2048, 0); put(2048, 0); put(4095, 0); put(2048, 0);
        idle(6);
        checks++; if (seen.size() != expq.size()) begin errors++; $display("FAIL peak_count: got %0d pulses, expected %0d", seen.size(), expq.size()); end
        foreach (expq[i]) if (i < seen.size()) begin
            checks++;
            if (seen[i] != expq[i]) begin errors++; $display("FAIL peak_pulse%0d: got cyc=%0d lvl=%0d led=%h hold=%0d, expected cyc=%0d lvl=%0d led=%h hold=%0d", i, seen[i].c, seen[i].lvl, seen[i].ld, seen[i].hld, expq[i].c, expq[i].lvl, expq[i].ld, expq[i].hld); end
            else $display("peak window %0d: level=%0d hold=%0d", i, seen[i].lvl, seen[i].hld);
        end
        checks++; if (level !== 5'd16 || led !== 16'hFFFF) begin errors++; $display("FAIL peak_full_scale: got level=%0d led=%h, expected 16 FFFF", level, led); end
        seen.delete(); expq.delete();
    endtask

    task automatic test_average();
        hold_en = 1'b0;
        repeat (4) put(3072, 1);
        idle(4);
        checks++; if (level !== 5'd8 || led !== 16'h00FF) begin errors++; $display("FAIL avg_level: got level=%0d led=%h, expected 8 00FF", level, led); end
        put(0, 0); put(2048, 0); put(2048, 0); put(2048, 0);
        idle(4);
        checks++; if (level !== 5'd16) begin errors++; $display("FAIL avg_saturate: got level=%0d, expected 16", level); end
        checks++; if (seen.size() != expq.size()) begin errors++; $display("FAIL avg_count: got %0d pulses, expected %0d", seen.size(), expq.size()); end
        foreach (expq[i]) if (i < seen.size()) begin
            checks++;
            if (seen[i] != expq[i]) begin errors++; $display("FAIL avg_pulse%0d: got cyc=%0d lvl=%0d led=%h hold=%0d, expected cyc=%0d lvl=%0d led=%h hold=%0d", i, seen[i].c, seen[i].lvl, seen[i].ld, seen[i].hld, expq[i].c, expq[i].lvl, expq[i].ld, expq[i].hld); end
            else $display("avg window %0d: level=%0d hold=%0d", i, seen[i].lvl, seen[i].hld);
        end
        seen.delete(); expq.delete();
    endtask

    task automatic test_hold();
        int peaks[5];
        int hold_on[5];
        int hold_off[5];
        peaks    = '{3494, 2530, 2530, 2530, 2530};
        hold_on  = '{12, 12, 11, 10, 9};
        hold_off = '{12, 4, 4, 4, 4};
        do_reset();
        for (int pass = 0; pass < 2; pass++) begin
            hold_en = (pass == 0);
            for (int w = 0; w < 5; w++) begin
                put(peaks[w], 0); put(2048, 0); put(2048, 0); put(2048, 0);
                idle(3);
            end
        end
        idle(3);
        checks++; if (seen.size() != expq.size()) begin errors++; $display("FAIL hold_count: got %0d pulses, expected %0d", seen.size(), expq.size()); end
        foreach (expq[i]) if (i < seen.size()) begin
            checks++;
            if (seen[i] != expq[i]) begin errors++; $display("FAIL hold_pulse%0d: got cyc=%0d lvl=%0d led=%h hold=%0d, expected cyc=%0d lvl=%0d led=%h hold=%0d", i, seen[i].c, seen[i].lvl, seen[i].ld, seen[i].hld, expq[i].c, expq[i].lvl, expq[i].ld, expq[i].hld); end
            else $display("hold window %0d: level=%0d hold=%0d", i, seen[i].lvl, seen[i].hld);
        end
        for (int i = 0; i < 10 && i < seen.size(); i++) begin
            checks++;
            if (seen[i].hld != ((i < 5) ? hold_on[i] : hold_off[i-5])) begin
                errors++; $display("FAIL hold_seq%0d: got %0d, expected %0d", i, seen[i].hld, (i < 5) ? hold_on[i] : hold_off[i-5]);
            end
        end
        seen.delete(); expq.delete();
    endtask

    task automatic test_back_to_back();
        hold_en = 1'b0;
        for (int i = 0; i < 3 * WN; i++) put(int'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)));
        idle(6);
        checks++; if (seen.size() != 3) begin errors++; $display("FAIL b2b_count: got %0d pulses, expected 3", seen.size()); end
        foreach (expq[i]) if (i < seen.size()) begin
            checks++;
            if (seen[i] != expq[i]) begin errors++; $display("FAIL b2b_pulse%0d: got cyc=%0d lvl=%0d led=%h hold=%0d, expected cyc=%0d lvl=%0d led=%h hold=%0d", i, seen[i].c, seen[i].lvl, seen[i].ld, seen[i].hld, expq[i].c, expq[i].lvl, expq[i].ld, expq[i].hld); end
            else $display("b2b window %0d: level=%0d hold=%0d", i, seen[i].lvl, seen[i].hld);
        end
        seen.delete(); expq.delete();
    endtask

    task automatic test_reset_mid_window();
        hold_en = 1'b1;
        put(4095, 0); put(4095, 0);
        RESET = 1'b1; sample_valid = 1'b1; sample = 12'hFFF;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLOCK);
            sample_valid = 1'b0;
            checks++;
            if (level !== 5'd0 || led !== 16'h0 || hold_level !== 5'd0 || level_valid !== 1'b0) begin
                errors++; $display("FAIL midreset_outputs%0d: got level=%0d led=%h hold=%0d valid=%b, expected all 0", i, level, led, hold_level, level_valid);
            end
        end
        RESET = 1'b0;
        win_mags.delete(); m_hold = 0; m_hcnt = 0;
        repeat (4) put(2048, 0);
        idle(6);
        checks++; if (level !== 5'd0 || hold_level !== 5'd0) begin errors++; $display("FAIL midreset_level: got level=%0d hold=%0d, expected 0 0", level, hold_level); end
        checks++; if (seen.size() != expq.size()) begin errors++; $display("FAIL midreset_count: got %0d pulses, expected %0d", seen.size(), expq.size()); end
        foreach (expq[i]) if (i < seen.size()) begin
            checks++;
            if (seen[i] != expq[i]) begin errors++; $display("FAIL midreset_pulse%0d: got cyc=%0d lvl=%0d led=%h hold=%0d, expected cyc=%0d lvl=%0d led=%h hold=%0d", i, seen[i].c, seen[i].lvl, seen[i].ld, seen[i].hld, expq[i].c, expq[i].lvl, expq[i].ld, expq[i].hld); end
            else $display("midreset window %0d: level=%0d hold=%0d", i, seen[i].lvl, seen[i].hld);
        end
        seen.delete(); expq.delete();
    endtask

    task automatic test_mode_switch();
        hold_en = 1'b0;
        put(3000, 0); put(2100, 0); put(2500, 1); put(2048, 1);
        put(3000, 1); put(2100, 1); put(2500, 1); put(2048, 1);
        idle(6);
        checks++; if (seen.size() != expq.size()) begin errors++; $display("FAIL mode_count: got %0d pulses, expected %0d", seen.size(), expq.size()); end
        foreach (expq[i]) if (i < seen.size()) begin
            checks++;
            if (seen[i] != expq[i]) begin errors++; $display("FAIL mode_pulse%0d: got cyc=%0d lvl=%0d led=%h hold=%0d, expected cyc=%0d lvl=%0d led=%h hold=%0d", i, seen[i].c, seen[i].lvl, seen[i].ld, seen[i].hld, expq[i].c, expq[i].lvl, expq[i].ld, expq[i].hld); end
            else $display("mode window %0d: level=%0d hold=%0d", i, seen[i].lvl, seen[i].hld);
        end
        seen.delete(); expq.delete();
    endtask

    task automatic test_random();
        for (int b = 0; b < 6; b++) begin
            hold_en = 1'($urandom_range(0, 1));
            for (int i = 0; i < 4 * WN; i++) begin
                put(int'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)));
                idle(int'($urandom_range(0, 2)));
            end
            idle(4);
        end
        checks++; if (seen.size() != expq.size()) begin errors++; $display("FAIL rand_count: got %0d pulses, expected %0d", seen.size(), expq.size()); end
        foreach (expq[i]) if (i < seen.size()) begin
            checks++;
            if (seen[i] != expq[i]) begin errors++; $display("FAIL rand_pulse%0d: got cyc=%0d lvl=%0d led=%h hold=%0d, expected cyc=%0d lvl=%0d led=%h hold=%0d", i, seen[i].c, seen[i].lvl, seen[i].ld, seen[i].hld, expq[i].c, expq[i].lvl, expq[i].ld, expq[i].hld); end
            else $display("rand window %0d: level=%0d hold=%0d", i, seen[i].lvl, seen[i].hld);
        end
        seen.delete(); expq.delete();
    endtask

    initial begin
        RESET = 1'b1; sample_valid = 1'b0; sample = '0; mode = 1'b0; hold_en = 1'b0;
        @(negedge CLOCK);
        test_reset();
        test_peak();
        test_average();
        test_hold();
        test_back_to_back();
        test_reset_mid_window();
        test_mode_switch();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
